vga_timing_gen: RTL and testbench

- Source end of the VGA timing interface consumed by the pipeline stages of the display path.
- Free-running horizontal and vertical counters generate hcount/vcount, hsync/vsync and hblnk/vblnk for 800x600 @ 60 Hz with a 40 MHz pixel clock.
- All outputs are registered and mutually consistent in every cycle, so downstream stages can register them straight through.
- Adds a pixel-enable input and a one-cycle frame_start strobe for frame-synchronous logic (e.g. game tick).

---
 rtl/vga_timing_gen.sv | 92 +++++++++
 tb/tb_vga_timing_gen.sv | 125 ++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA 800x600@60 timing generator with pixel enable and frame strobe
// Counters and every decoded output are registered on the same edge, so all outputs describe one pixel.
module vga_timing_gen #(
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 40,
  parameter int H_SYNC   = 128,
  parameter int H_BP     = 88,
  parameter int V_ACTIVE = 600,
  parameter int V_FP     = 1,
  parameter int V_SYNC   = 4,
  parameter int V_BP     = 23,
  parameter bit SYNC_POL = 1'b1
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        en,
  output logic [11:0] hcount,
  output logic        hsync,
  output logic        hblnk,
  output logic [11:0] vcount,
  output logic        vsync,
  output logic        vblnk,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST   = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_ACT    = 12'(H_ACTIVE);
  localparam logic [11:0] V_ACT    = 12'(V_ACTIVE);
  localparam logic [11:0] HS_START = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [11:0] VS_START = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_END   = 12'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic        POL      = SYNC_POL;

  logic [11:0] hcount_q, hcount_d;
  logic [11:0] vcount_q, vcount_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        hblnk_q, hblnk_d;
  logic        vblnk_q, vblnk_d;
  logic        frame_q, frame_d;

  // Decode is taken from the next counter values so it lands in the same register stage as the counts.
  always_comb begin
    hcount_d = hcount_q + 12'd1;
    vcount_d = vcount_q;
    if (hcount_q == H_LAST) begin
      hcount_d = 12'd0;
      vcount_d = (vcount_q == V_LAST) ? 12'd0 : vcount_q + 12'd1;
    end
    hblnk_d = (hcount_d >= H_ACT);
    vblnk_d = (vcount_d >= V_ACT);
    hsync_d = ((hcount_d >= HS_START) && (hcount_d <= HS_END)) ? POL : ~POL;
    vsync_d = ((vcount_d >= VS_START) && (vcount_d <= VS_END)) ? POL : ~POL;
    frame_d = (hcount_d == 12'd0) && (vcount_d == 12'd0);
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      hcount_q <= 12'd0;
      vcount_q <= 12'd0;
      hblnk_q  <= 1'b0;
      vblnk_q  <= 1'b0;
      hsync_q  <= ~POL;
      vsync_q  <= ~POL;
      frame_q  <= 1'b0;
    end else if (en) begin
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
      hblnk_q  <= hblnk_d;
      vblnk_q  <= vblnk_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      frame_q  <= frame_d;
    end else begin
      frame_q  <= 1'b0;
    end
  end

  assign hcount      = hcount_q;
  assign vcount      = vcount_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign hblnk       = hblnk_q;
  assign vblnk       = vblnk_q;
  assign frame_start = frame_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - randomized check of vga_timing_gen against a position-arithmetic model
// Three instances share stimulus: full 800x600 timing, and a tiny frame in both sync polarities.
module tb_vga_timing_gen;

  logic pclk = 1'b0;
  logic rst  = 1'b1;
  logic en   = 1'b0;

  always #5 pclk = ~pclk;

  logic [11:0] a_hc, a_vc, b_hc, b_vc, c_hc, c_vc;
  logic        a_hs, a_hb, a_vs, a_vb, a_fs;
  logic        b_hs, b_hb, b_vs, b_vb, b_fs;
  logic        c_hs, c_hb, c_vs, c_vb, c_fs;

  vga_timing_gen u_a (
    .pclk(pclk), .rst(rst), .en(en),
    .hcount(a_hc), .hsync(a_hs), .hblnk(a_hb),
    .vcount(a_vc), .vsync(a_vs), .vblnk(a_vb), .frame_start(a_fs)
  );

  vga_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
    .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(2), .SYNC_POL(1'b1)
  ) u_b (
    .pclk(pclk), .rst(rst), .en(en),
    .hcount(b_hc), .hsync(b_hs), .hblnk(b_hb),
    .vcount(b_vc), .vsync(b_vs), .vblnk(b_vb), .frame_start(b_fs)
  );

  vga_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
    .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(2), .SYNC_POL(1'b0)
  ) u_c (
    .pclk(pclk), .rst(rst), .en(en),
    .hcount(c_hc), .hsync(c_hs), .hblnk(c_hb),
    .vcount(c_vc), .vsync(c_vs), .vblnk(c_vb), .frame_start(c_fs)
  );

  localparam int A_HT = 1056, A_VT = 628;
  localparam int S_HT = 25,   S_VT = 13;

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned n     = 0;   // en-high edges since the last reset
  bit          fs_a  = 1'b0;
  bit          fs_s  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic chk_inst(input string tg, input bit fs, input int ha, input int hfp, input int hs,
                          input int hbp, input int va, input int vfp, input int vs, input int vbp,
                          input bit pol, input logic [11:0] hc, input logic [11:0] vc,
                          input logic hsy, input logic hbl, input logic vsy, input logic vbl,
                          input logic fso);
    int ht, vt, pos, h, v;
    bit h_on, v_on;
    ht   = ha + hfp + hs + hbp;
    vt   = va + vfp + vs + vbp;
    pos  = int'(n % (ht * vt));
    h    = pos % ht;
    v    = pos / ht;
    h_on = (h >= ha + hfp) && (h < ha + hfp + hs);
    v_on = (v >= va + vfp) && (v < va + vfp + vs);
    chk({tg, "_hcount"}, 32'(hc), 32'(h));
    chk({tg, "_vcount"}, 32'(vc), 32'(v));
    chk({tg, "_hblnk"},  32'(hbl), 32'(h >= ha));
    chk({tg, "_vblnk"},  32'(vbl), 32'(v >= va));
    chk({tg, "_hsync"},  32'(hsy), 32'(h_on ? pol : !pol));
    chk({tg, "_vsync"},  32'(vsy), 32'(v_on ? pol : !pol));
    chk({tg, "_frame"},  32'(fso), 32'(fs));
  endtask

  task automatic step(input bit r, input bit e);
    rst = r;
    en  = e;
    @(posedge pclk);
    if (r) begin
      n = 0; fs_a = 1'b0; fs_s = 1'b0;
    end else if (e) begin
      n++;
      fs_a = (n % (A_HT * A_VT)) == 0;
      fs_s = (n % (S_HT * S_VT)) == 0;
    end else begin
      fs_a = 1'b0; fs_s = 1'b0;
    end
    #1;
    chk_inst("a", fs_a, 800, 40, 128, 88, 600, 1, 4, 23, 1'b1,
             a_hc, a_vc, a_hs, a_hb, a_vs, a_vb, a_fs);
    chk_inst("b", fs_s, 16, 2, 4, 3, 8, 1, 2, 2, 1'b1,
             b_hc, b_vc, b_hs, b_hb, b_vs, b_vb, b_fs);
    chk_inst("c", fs_s, 16, 2, 4, 3, 8, 1, 2, 2, 1'b0,
             c_hc, c_vc, c_hs, c_hb, c_vs, c_vb, c_fs);
  endtask

  initial begin
    int guard;
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    // first line of the full-size timing, plus several small frames
    for (int i = 0; i < 1100; i++) step(1'b0, 1'b1);
    for (int i = 0; i < 1500; i++) step(1'b0, 1'(($urandom & 32'h3) != 0));
    // arm a reset while the small frame sits inside both sync windows
    guard = 0;
    while (!(((n % (S_HT * S_VT)) % S_HT == 19) && ((n % (S_HT * S_VT)) / S_HT == 9))
           && guard < 400) begin
      step(1'b0, 1'b1);
      guard++;
    end
    chk("reset_arm", 32'(guard < 400), 32'd1);
    step(1'b1, 1'b1);
    for (int i = 0; i < 400; i++) step(1'b0, 1'b1);
    for (int i = 0; i < 700; i++) step(1'b0, 1'(i % 2 == 0));
    for (int i = 0; i < 300; i++) step(1'b0, 1'($urandom_range(0, 1)));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
